select_issuer_3_8: RTL

Reverse-direction companion to the 8:3 priority index encoder. Accepts 3-bit port indices through a valid/ready input, buffers them in order, and issues each as a registered one-hot 8-bit select over a valid/ready output. Tracks a per-port busy mask and holds issue while the target port is still busy. It sits between the scheduler that produces port indices and the 8-port datapath that consumes one-hot selects.

---
 rtl/select_issuer_3_8_if.sv | 33 +++
 rtl/select_issuer_3_8.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/select_issuer_3_8_if.sv
// select_issuer_3_8_if
// Handshake bundle for the select issuer.
//   in_valid/in_idx/in_ready     : 3-bit port index input, valid/ready
//   out_valid/out_select/out_ready : one-hot 8-bit select output, valid/ready
// Modports:
//   slave  : issuer side (consumes indices, produces selects)
//   master : environment side (scheduler plus datapath)
interface select_issuer_3_8_if;
    logic       in_valid;
    logic [2:0] in_idx;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_select;
    logic       out_ready;

    modport slave (
        input  in_valid,
        input  in_idx,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_select
    );

    modport master (
        output in_valid,
        output in_idx,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_select
    );
endinterface

// File: rtl/select_issuer_3_8.sv
// select_issuer_3_8
// Buffers 3-bit port indices in an in-order FIFO and issues each one as a
// registered one-hot 8-bit select. Issue is held while the target port is
// still marked busy.
// Ports:
//   clk        : system clock, all state on the rising edge
//   rst_n      : synchronous active-low reset
//   bus        : index input and select output handshakes (slave modport)
//   release_i  : per-port pulse that clears the matching busy bit
//   busy_o     : registered per-port busy mask
//   count_o    : FIFO occupancy, not counting the output stage
module select_issuer_3_8 #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    select_issuer_3_8_if.slave       bus,
    input  logic [7:0]               release_i,
    output logic [7:0]               busy_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Decode a port index into its one-hot select.
    function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    logic [2:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    state_t        state_q,  state_d;
    logic [7:0]    sel_q,    sel_d;
    logic [7:0]    busy_q,   busy_d;

    logic       push_s;
    logic       consume_s;
    logic       eligible_s;
    logic       load_s;
    logic [2:0] head_s;

    assign head_s    = mem_q[rd_ptr_q];
    assign push_s    = bus.in_valid && bus.in_ready;
    assign consume_s = bus.out_valid && bus.out_ready;
    // A head whose port is still busy, or which is the select currently
    // held, must wait; this blocks every entry queued behind it.
    assign eligible_s = (count_q != {CW{1'b0}}) && !busy_q[head_s] &&
                        !(bus.out_valid && sel_q[head_s]);
    assign load_s     = eligible_s && ((state_q == ST_EMPTY) || consume_s);

    assign bus.in_ready   = (count_q < DEPTH_C);
    assign bus.out_valid  = (state_q == ST_HOLD);
    assign bus.out_select = sel_q;
    assign busy_o         = busy_q;
    assign count_o        = count_q;

    // Next-state logic for the output stage, FIFO pointers and busy mask.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // Set after clear, so a port issued this cycle stays busy even if
        // its release bit pulses in the same cycle.
        busy_d   = (busy_q & ~release_i) | (consume_s ? sel_q : 8'h00);

        case (state_q)
            ST_EMPTY: begin
                if (load_s) begin
                    state_d  = ST_HOLD;
                    sel_d    = idx_to_onehot(head_s);
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end else begin
                    state_d = ST_EMPTY;
                    sel_d   = 8'h00;
                end
            end
            ST_HOLD: begin
                if (load_s) begin
                    state_d  = ST_HOLD;
                    sel_d    = idx_to_onehot(head_s);
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end else if (consume_s) begin
                    state_d = ST_EMPTY;
                    sel_d   = 8'h00;
                end else begin
                    state_d = ST_HOLD;
                    sel_d   = sel_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                sel_d   = 8'h00;
            end
        endcase

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_s, load_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            sel_q    <= 8'h00;
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            busy_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.in_idx;
        end
    end

endmodule
